// File: rtl/cla_sum_seq.sv
// Sequential carry-lookahead sum stage: resolves one GROUP-bit nibble of carries per cycle.
// Optional o_zero/o_ovf status flags are built when STATUS_FLAGS_EN is defined.
module cla_sum_seq #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_g,
  input  logic             i_cin,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_valid,
  input  logic             i_ready
`ifdef STATUS_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_ovf
`endif
);

  // state  | meaning
  // S_IDLE | waiting for operands, o_ready=1
  // S_CALC | resolving nibble idx_q per cycle
  // S_DONE | result held, o_valid=1 until i_ready
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int NGRP = WIDTH / GROUP;
  localparam int IDXW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NGRP - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  p_q, g_q, sum_q, sum_next;
  logic              c_q, cout_q;
  logic [IDXW-1:0]   idx_q;
  logic [GROUP-1:0]  p_nib, g_nib, s_nib;
  logic [GROUP:0]    c_vec;
  logic              accept, last;

  always_comb begin
    p_nib    = p_q[idx_q*GROUP +: GROUP];
    g_nib    = g_q[idx_q*GROUP +: GROUP];
    c_vec    = '0;
    s_nib    = '0;
    c_vec[0] = c_q;
    for (int k = 0; k < GROUP; k++) begin
      c_vec[k+1] = g_nib[k] | (p_nib[k] & c_vec[k]);
      s_nib[k]   = p_nib[k] ^ c_vec[k];
    end
    sum_next = sum_q;
    sum_next[idx_q*GROUP +: GROUP] = s_nib;
  end

  assign accept = i_valid && (state_q == S_IDLE);
  assign last   = (idx_q == IDX_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = S_CALC;
      end
      S_CALC: if (last) state_d = S_DONE;
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_q    <= '0;
      g_q    <= '0;
      c_q    <= 1'b0;
      idx_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      p_q   <= i_p;
      g_q   <= i_g;
      c_q   <= i_cin;
      idx_q <= '0;
    end else if (state_q == S_CALC) begin
      sum_q <= sum_next;
      c_q   <= c_vec[GROUP];
      // idx holds at the last nibble rather than wrapping
      if (last) cout_q <= c_vec[GROUP];
      else      idx_q  <= idx_q + 1'b1;
    end
  end

`ifdef STATUS_FLAGS_EN
  logic zero_q, ovf_q, c_msb;

  // carry into the MSB of the final nibble, i.e. into bit WIDTH-1
  assign c_msb = c_vec[GROUP-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == S_CALC && last) begin
      zero_q <= (sum_next == '0);
      ovf_q  <= c_vec[GROUP] ^ c_msb;
    end
  end

  assign o_zero = zero_q;
  assign o_ovf  = ovf_q;
`endif

  assign o_sum  = sum_q;
  assign o_cout = cout_q;

endmodule

// File: tb/tb_cla_sum_seq.sv
// Directed self-checking bench for cla_sum_seq (WIDTH=32, GROUP=4).
// Flag checks are included when STATUS_FLAGS_EN is defined.
module tb_cla_sum_seq;
  logic        clk;
  logic        rst_n;
  logic [31:0] p, g;
  logic        cin, in_valid, out_ready;
  logic        ready, out_valid, cout;
  logic [31:0] sum;
`ifdef STATUS_FLAGS_EN
  logic        zero, ovf;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  cla_sum_seq #(.WIDTH(32), .GROUP(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_p     (p),
    .i_g     (g),
    .i_cin   (cin),
    .i_valid (in_valid),
    .o_ready (ready),
    .o_sum   (sum),
    .o_cout  (cout),
    .o_valid (out_valid),
    .i_ready (out_ready)
`ifdef STATUS_FLAGS_EN
    ,
    .o_zero  (zero),
    .o_ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation from IDLE; returns cycles from accept edge to o_valid, -1 on timeout.
  task automatic start_op(input logic [31:0] tp, input logic [31:0] tg, input logic tc,
                          output int lat);
    @(negedge clk);
    p = tp; g = tg; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h0 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: ready=%b valid=%b sum=%h cout=%b, required 1 0 0 0",
               ready, out_valid, sum, cout);
    end
`ifdef STATUS_FLAGS_EN
    tests_run++;
    if (zero !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: zero=%b ovf=%b, required 0 0", zero, ovf);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    start_op(32'h0000000F, 32'h0, 1'b0, lat);
    tests_run++;
    if (lat !== 8) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d, required 8", lat);
    end
    tests_run++;
    if (sum !== 32'h0000000F || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_sum: sum=%h cout=%b, required 0000000f 0", sum, cout);
    end
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_ready_in_done: got %b, required 0", ready);
    end
    release_result();
    tests_run++;
    if (ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_release: ready=%b valid=%b, required 1 0", ready, out_valid);
    end
  endtask

  task automatic test_ripple();
    int lat;
    start_op(32'hFFFFFFFE, 32'h00000001, 1'b0, lat);
    tests_run++;
    if (lat !== 8 || sum !== 32'h0 || cout !== 1'b1) begin
      tests_failed++;
      $display("FAIL ripple: lat=%0d sum=%h cout=%b, required 8 00000000 1", lat, sum, cout);
    end
`ifdef STATUS_FLAGS_EN
    tests_run++;
    if (zero !== 1'b1 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL ripple_flags: zero=%b ovf=%b, required 1 0", zero, ovf);
    end
`endif
    release_result();
  endtask

  task automatic test_sub();
    int lat;
    start_op(32'hFFFFFFF9, 32'h00000004, 1'b1, lat);
    tests_run++;
    if (lat !== 8 || sum !== 32'h00000002 || cout !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub: lat=%0d sum=%h cout=%b, required 8 00000002 1", lat, sum, cout);
    end
`ifdef STATUS_FLAGS_EN
    tests_run++;
    if (zero !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_flags: zero=%b ovf=%b, required 0 0", zero, ovf);
    end
`endif
    release_result();
  endtask

  task automatic test_ovf();
    int lat;
    start_op(32'h7FFFFFFE, 32'h00000001, 1'b0, lat);
    tests_run++;
    if (lat !== 8 || sum !== 32'h80000000 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf: lat=%0d sum=%h cout=%b, required 8 80000000 0", lat, sum, cout);
    end
`ifdef STATUS_FLAGS_EN
    tests_run++;
    if (zero !== 1'b0 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_flags: zero=%b ovf=%b, required 0 1", zero, ovf);
    end
`endif
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(32'h0000000F, 32'h0, 1'b0, lat);
    // new operands offered during DONE must be ignored
    p = 32'h12345678; g = 32'h0; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || sum !== 32'h0000000F || ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: valid=%b sum=%h ready=%b, required 1 0000000f 0",
                 i, out_valid, sum, ready);
      end
    end
    // both handshakes high: only the result handshake may fire this edge
    p = 32'h7FFFFFFE; g = 32'h00000001; cin = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: ready=%b valid=%b, required 1 0", ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    tests_run++;
    if (lat !== 8 || sum !== 32'h80000000 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back: lat=%0d sum=%h cout=%b, required 8 80000000 0", lat, sum, cout);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    p = 32'hFFFFFFFE; g = 32'h00000001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || ready !== 1'b1 || sum !== 32'h0 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: valid=%b ready=%b sum=%h cout=%b, required 0 1 00000000 0",
               out_valid, ready, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'h0000000F, 32'h0, 1'b0, lat);
    tests_run++;
    if (lat !== 8 || sum !== 32'h0000000F || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_op: lat=%0d sum=%h cout=%b, required 8 0000000f 0", lat, sum, cout);
    end
    release_result();
  endtask

  initial begin
    rst_n = 1'b0; p = '0; g = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_sub();
    test_ovf();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end
endmodule
